tail_input_conditioner: RTL
===========================

Name: tail_input_conditioner

Overview:
- Front-end stage for the tail-light sequencer; it feeds the sequencer directly.
- Synchronizes and debounces the four raw switch inputs (left, right, brake, hazard).
- Generates the one-cycle step pulse that advances the sequencer's pattern state at the blink rate.
- Restarts the blink cadence whenever the conditioned control vector changes, so a new mode takes effect immediately.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a debounced output follows its input (10 ms at 50 MHz); legal range >= 1.
- TICK_DIV, 12500000: step period in clk cycles (4 Hz at 50 MHz); legal range >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset. Low forces reset immediately, without a clock. Deassertion is synchronized upstream.
- left_raw  input  1  raw left-turn switch, asynchronous.
- right_raw  input  1  raw right-turn switch, asynchronous.
- brake_raw  input  1  raw brake switch, asynchronous.
- hazard_raw  input  1  raw hazard switch, asynchronous.
- left  output  1  debounced left, registered.
- right  output  1  debounced right, registered.
- brake  output  1  debounced brake, registered.
- hazard  output  1  debounced hazard, registered.
- step  output  1  one-cycle advance pulse to the sequencer, registered.

Behaviour:
- Reset (rst low):
  - Sync flops, debounce counters and tick counter go to 0.
  - left, right, brake, hazard and step go to 0.
  - Applies mid-operation with no clock required; partial debounce progress is discarded.
- Synchronizer:
  - Two flops per input; s2 is the synchronized value.
- Debounce, per input, independent:
  - If s2 == output: counter cleared to 0.
  - If s2 != output and counter == DEBOUNCE_CYCLES-1: output <= s2, counter <= 0.
  - Otherwise: counter increments.
  - Counter width is $clog2(DEBOUNCE_CYCLES), minimum 1 bit. The counter never wraps.
- Latency: a raw level held stable appears at the output on the (2+DEBOUNCE_CYCLES)th rising edge after it is first sampled.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES cycles at s2 produces no output change. Its counter clears when s2 returns to match the output.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - step <= 1 on the edge where the counter is at TICK_DIV-1; else 0.
  - step is high for exactly one cycle.
- Resync:
  - On any edge where at least one debounced output changes value: tick counter <= 0 and step <= 1 on that same edge.
  - The new control values and the step pulse are therefore visible in the same cycle.
- Simultaneous events:
  - Several inputs updating on one edge produce one step pulse.
  - Terminal count coinciding with a control change produces one step pulse; the counter goes to 0, not a double pulse.
- After a resync, the next periodic step occurs TICK_DIV cycles after the resync pulse.
- No combinational path from any input to any output.

Optional Feature:
- Macro: TAIL_BRAKE_FASTPATH_EN.
- Defined:
  - A brake rise bypasses debounce: when s2_brake == 1 and brake == 0, brake <= 1 on the next edge (3 edges after sampling), with a resync step and the brake counter cleared.
  - Brake release (1->0) is still fully debounced.
  - left, right and hazard are unaffected.
- Undefined: brake is debounced in both directions, identical to the other inputs.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=8 unless stated):
- Reset: hold inputs high until outputs are 1, then drive rst low between clock edges -> all outputs 0 immediately. After release with inputs held high -> outputs return to 1 six edges later.
- left_raw 0->1 held, no macro -> left rises on edge 6 with step=1 that cycle; further steps at +8, +16 cycles, each one cycle wide.
- right_raw high for 3 cycles, then low -> right stays 0 and no extra step occurs; periodic steps keep an exact 8-cycle spacing.
- No input activity for 64 cycles -> exactly 8 step pulses, spaced 8 cycles apart.
- left_raw and hazard_raw rise together, with the rise timed so their update edge equals the tick terminal count -> both outputs rise on the same edge, a single step pulse, next step 8 cycles later.
- TAIL_BRAKE_FASTPATH_EN defined: brake_raw 0->1 -> brake=1 and step=1 on edge 3; brake_raw 1->0 -> brake=0 on edge 6. Macro undefined -> brake rises on edge 6.

Source files
------------

// File: rtl/tail_input_conditioner.sv
// Tail-light front end: 2-flop sync + debounce of four switches and a blink-rate step pulse.
// Optional macro TAIL_BRAKE_FASTPATH_EN lets a brake press bypass debounce (release stays debounced).
module tail_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic left_raw,
  input  logic right_raw,
  input  logic brake_raw,
  input  logic hazard_raw,
  output logic left,
  output logic right,
  output logic brake,
  output logic hazard,
  output logic step
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // bit order: 0 left, 1 right, 2 brake, 3 hazard
  logic [3:0]    raw;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    db;
  logic [3:0]    db_nxt;
  logic [CW-1:0] cnt     [4];
  logic [CW-1:0] cnt_nxt [4];
  logic [TW-1:0] tick;
  logic          step_q;
  logic          ctl_change;

  assign raw = {hazard_raw, brake_raw, right_raw, left_raw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_comb begin
    db_nxt = db;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != db[i]) begin
        if (cnt[i] == CNT_LAST) db_nxt[i] = s2[i];
        else                    cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
`ifdef TAIL_BRAKE_FASTPATH_EN
    if (s2[2] && !db[2]) begin
      db_nxt[2]  = 1'b1;
      cnt_nxt[2] = '0;
    end
`endif
    ctl_change = |(db_nxt ^ db);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      db <= db_nxt;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // A control change restarts the cadence so the new mode shows at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick   <= '0;
      step_q <= 1'b0;
    end else if (ctl_change || tick == TICK_LAST) begin
      tick   <= '0;
      step_q <= 1'b1;
    end else begin
      tick   <= tick + TW'(1);
      step_q <= 1'b0;
    end
  end

  assign left   = db[0];
  assign right  = db[1];
  assign brake  = db[2];
  assign hazard = db[3];
  assign step   = step_q;

endmodule
